// File: rtl/cp0_exc_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// cp0_exc_sequencer_pkg
//   Shared definitions for the commit-stage exception sequencer:
//   - EXC_CAUSE_* exception codes (same values as Exception.v)
//   - CP0 register addresses
//   - Status register bit positions
//   - Sequencer state encoding
//   - Latched commit record and the interrupt-take helper
// ---------------------------------------------------------------------------
package cp0_exc_sequencer_pkg;

   // Exception codes (Cause.ExcCode). NOP is an out-of-band "no exception" marker.
   localparam logic [4:0] EXC_CAUSE_INT  = 5'h00;
   localparam logic [4:0] EXC_CAUSE_MOD  = 5'h01;
   localparam logic [4:0] EXC_CAUSE_TLBL = 5'h02;
   localparam logic [4:0] EXC_CAUSE_TLBS = 5'h03;
   localparam logic [4:0] EXC_CAUSE_ADEL = 5'h04;
   localparam logic [4:0] EXC_CAUSE_ADES = 5'h05;
   localparam logic [4:0] EXC_CAUSE_IBE  = 5'h06;
   localparam logic [4:0] EXC_CAUSE_DBE  = 5'h07;
   localparam logic [4:0] EXC_CAUSE_SYS  = 5'h08;
   localparam logic [4:0] EXC_CAUSE_BP   = 5'h09;
   localparam logic [4:0] EXC_CAUSE_RI   = 5'h0A;
   localparam logic [4:0] EXC_CAUSE_CPU  = 5'h0B;
   localparam logic [4:0] EXC_CAUSE_OV   = 5'h0C;
   localparam logic [4:0] EXC_CAUSE_TR   = 5'h0D;
   localparam logic [4:0] EXC_CAUSE_NOP  = 5'h1F;

   // CP0 register addresses
   localparam logic [4:0] CP0_ADDR_BADVADDR = 5'd8;
   localparam logic [4:0] CP0_ADDR_COUNT    = 5'd9;
   localparam logic [4:0] CP0_ADDR_COMPARE  = 5'd11;
   localparam logic [4:0] CP0_ADDR_STATUS   = 5'd12;
   localparam logic [4:0] CP0_ADDR_CAUSE    = 5'd13;
   localparam logic [4:0] CP0_ADDR_EPC      = 5'd14;

   // Status bit positions
   localparam int STATUS_IE_BIT  = 0;
   localparam int STATUS_EXL_BIT = 1;
   localparam int STATUS_IM_LO   = 10;
   localparam int STATUS_IM_HI   = 15;

   // Sequencer state encoding
   localparam logic [2:0] SEQ_IDLE     = 3'd0;
   localparam logic [2:0] SEQ_ENTRY    = 3'd1;
   localparam logic [2:0] SEQ_ERET     = 3'd2;
   localparam logic [2:0] SEQ_FLUSH    = 3'd3;
   localparam logic [2:0] SEQ_REDIRECT = 3'd4;

   // Information captured from the winning commit in IDLE
   typedef struct packed {
      logic [31:0] pc;
      logic        in_ds;
      logic [4:0]  cause;
   } commit_latch_t;

   // An interrupt is taken when any enabled line is pending, interrupts are
   // globally enabled and we are not already at exception level.
   function automatic logic int_take_f(input logic [5:0] lines,
                                       input logic [5:0] im,
                                       input logic       ie,
                                       input logic       exl);
      return (|(lines & im)) & ie & ~exl;
   endfunction

endpackage

// File: rtl/cp0_exc_sequencer_sync.sv
// ---------------------------------------------------------------------------
// cdc_sync2
//   Parameterized-width two-flop synchronizer with asynchronous active-low
//   reset. Each bit is synchronized independently (no bus coherency).
// Ports:
//   clk     in  1      destination clock
//   resetn  in  1      asynchronous active-low reset
//   i_d     in  WIDTH  asynchronous input
//   o_q     out WIDTH  synchronized output, 2-cycle latency
// ---------------------------------------------------------------------------
module cdc_sync2 #(
   parameter int WIDTH = 6
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_meta;
   logic [WIDTH-1:0] r_sync;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_meta <= '0;
         r_sync <= '0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/cp0_exc_sequencer.sv
// ---------------------------------------------------------------------------
// cp0_exc_sequencer
//   Commit-stage exception/interrupt sequencer in front of CP0. Picks one of
//   {interrupt, committing exception, ERET}, pulses CP0's exception or ERET
//   inputs for one cycle, holds o_flush for FLUSH_CYCLES cycles, then offers
//   the redirect target (handler vector or EPC) to fetch with valid/ready.
// Ports:
//   clk, resetn             clock, asynchronous active-low reset
//   i_commit_valid/cause/pc/in_ds/eret   committing instruction info
//   i_int_raw [5:0]         raw asynchronous interrupt lines
//   i_cp0_status, i_cp0_epc CP0 Status and EPC
//   o_cp0_int               synchronized interrupt lines to CP0
//   o_cp0_except_cause/current_pc/in_ds/eret   CP0 exception/ERET inputs
//   o_stall_commit          hold commit stage (state != IDLE)
//   o_flush                 kill younger instructions
//   o_redirect_valid/pc, i_redirect_ready       redirect handshake to fetch
// ---------------------------------------------------------------------------
module cp0_exc_sequencer
   import cp0_exc_sequencer_pkg::*;
#(
   parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
   parameter int unsigned FLUSH_CYCLES = 2
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        i_commit_valid,
   input  logic [4:0]  i_commit_cause,
   input  logic [31:0] i_commit_pc,
   input  logic        i_commit_in_ds,
   input  logic        i_commit_eret,
   input  logic [5:0]  i_int_raw,
   input  logic [31:0] i_cp0_status,
   input  logic [31:0] i_cp0_epc,
   output logic [5:0]  o_cp0_int,
   output logic [4:0]  o_cp0_except_cause,
   output logic [31:0] o_cp0_current_pc,
   output logic        o_cp0_in_ds,
   output logic        o_cp0_eret,
   output logic        o_stall_commit,
   output logic        o_flush,
   output logic        o_redirect_valid,
   output logic [31:0] o_redirect_pc,
   input  logic        i_redirect_ready
);

   localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

   logic [2:0]    r_state;
   logic [2:0]    w_state_next;
   logic [3:0]    r_flush_cnt;
   logic [3:0]    w_flush_cnt_next;
   commit_latch_t r_latch;
   commit_latch_t w_latch_next;
   logic [31:0]   r_target;
   logic [31:0]   w_target_next;
   logic [5:0]    w_int_sync;
   logic          w_int_take;
   logic          w_unused_status_bits;

   cdc_sync2 #(.WIDTH(6)) u_int_sync (
      .clk    (clk),
      .resetn (resetn),
      .i_d    (i_int_raw),
      .o_q    (w_int_sync)
   );

   assign w_int_take = int_take_f(w_int_sync,
                                  i_cp0_status[STATUS_IM_HI:STATUS_IM_LO],
                                  i_cp0_status[STATUS_IE_BIT],
                                  i_cp0_status[STATUS_EXL_BIT]);

   // Status fields this block does not look at
   assign w_unused_status_bits = ^{i_cp0_status[31:16], i_cp0_status[9:2]};

   always_comb begin
      w_state_next     = r_state;
      w_flush_cnt_next = r_flush_cnt;
      w_latch_next     = r_latch;
      w_target_next    = r_target;
      case (r_state)
         SEQ_IDLE: begin
            // Interrupts only get in on a valid commit so EPC is a real PC
            if (i_commit_valid) begin
               if (w_int_take) begin
                  w_latch_next = '{pc: i_commit_pc, in_ds: i_commit_in_ds,
                                   cause: EXC_CAUSE_INT};
                  w_state_next = SEQ_ENTRY;
               end else if (i_commit_cause != EXC_CAUSE_NOP) begin
                  w_latch_next = '{pc: i_commit_pc, in_ds: i_commit_in_ds,
                                   cause: i_commit_cause};
                  w_state_next = SEQ_ENTRY;
               end else if (i_commit_eret) begin
                  w_state_next = SEQ_ERET;
               end
            end
         end
         SEQ_ENTRY: begin
            // Entered even with EXL=1; CP0 itself decides not to overwrite EPC
            w_target_next    = EXC_VECTOR;
            w_flush_cnt_next = FLUSH_LOAD;
            w_state_next     = SEQ_FLUSH;
         end
         SEQ_ERET: begin
            // EPC sampled in the same cycle CP0 sees the ERET pulse
            w_target_next    = i_cp0_epc;
            w_flush_cnt_next = FLUSH_LOAD;
            w_state_next     = SEQ_FLUSH;
         end
         SEQ_FLUSH: begin
            // <= 1 also guards against a zero load leaving us stuck
            if (r_flush_cnt <= 4'd1) begin
               w_flush_cnt_next = 4'd0;
               w_state_next     = SEQ_REDIRECT;
            end else begin
               w_flush_cnt_next = r_flush_cnt - 4'd1;
            end
         end
         SEQ_REDIRECT: begin
            if (i_redirect_ready) begin
               w_state_next = SEQ_IDLE;
            end
         end
         default: begin
            w_state_next = SEQ_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state     <= SEQ_IDLE;
         r_flush_cnt <= 4'd0;
         r_latch     <= '{pc: 32'd0, in_ds: 1'b0, cause: EXC_CAUSE_NOP};
         r_target    <= 32'd0;
      end else begin
         r_state     <= w_state_next;
         r_flush_cnt <= w_flush_cnt_next;
         r_latch     <= w_latch_next;
         r_target    <= w_target_next;
      end
   end

   // Outputs decode directly from registered state so reset clears them at once
   assign o_cp0_int          = w_int_sync;
   assign o_cp0_except_cause = (r_state == SEQ_ENTRY) ? r_latch.cause : EXC_CAUSE_NOP;
   assign o_cp0_current_pc   = r_latch.pc;
   assign o_cp0_in_ds        = r_latch.in_ds;
   assign o_cp0_eret         = (r_state == SEQ_ERET);
   assign o_stall_commit     = (r_state != SEQ_IDLE);
   assign o_flush            = (r_state == SEQ_FLUSH);
   assign o_redirect_valid   = (r_state == SEQ_REDIRECT);
   assign o_redirect_pc      = r_target;

endmodule

// File: tb/tb_cp0_exc_sequencer.sv
module tb_cp0_exc_sequencer;
   import cp0_exc_sequencer_pkg::*;

   logic        clk;
   logic        resetn;
   logic        i_commit_valid;
   logic [4:0]  i_commit_cause;
   logic [31:0] i_commit_pc;
   logic        i_commit_in_ds;
   logic        i_commit_eret;
   logic [5:0]  i_int_raw;
   logic [31:0] i_cp0_status;
   logic [31:0] i_cp0_epc;
   logic [5:0]  o_cp0_int;
   logic [4:0]  o_cp0_except_cause;
   logic [31:0] o_cp0_current_pc;
   logic        o_cp0_in_ds;
   logic        o_cp0_eret;
   logic        o_stall_commit;
   logic        o_flush;
   logic        o_redirect_valid;
   logic [31:0] o_redirect_pc;
   logic        i_redirect_ready;

   int pass_cnt = 0;
   int total_cnt = 0;

   localparam logic [31:0] VEC = 32'hBFC0_0380;

   cp0_exc_sequencer dut (
      .clk                (clk),
      .resetn             (resetn),
      .i_commit_valid     (i_commit_valid),
      .i_commit_cause     (i_commit_cause),
      .i_commit_pc        (i_commit_pc),
      .i_commit_in_ds     (i_commit_in_ds),
      .i_commit_eret      (i_commit_eret),
      .i_int_raw          (i_int_raw),
      .i_cp0_status       (i_cp0_status),
      .i_cp0_epc          (i_cp0_epc),
      .o_cp0_int          (o_cp0_int),
      .o_cp0_except_cause (o_cp0_except_cause),
      .o_cp0_current_pc   (o_cp0_current_pc),
      .o_cp0_in_ds        (o_cp0_in_ds),
      .o_cp0_eret         (o_cp0_eret),
      .o_stall_commit     (o_stall_commit),
      .o_flush            (o_flush),
      .o_redirect_valid   (o_redirect_valid),
      .o_redirect_pc      (o_redirect_pc),
      .i_redirect_ready   (i_redirect_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic commit(input logic [4:0] cause, input logic [31:0] pc,
                         input logic ds, input logic eret);
      i_commit_valid = 1'b1;
      i_commit_cause = cause;
      i_commit_pc    = pc;
      i_commit_in_ds = ds;
      i_commit_eret  = eret;
   endtask

   task automatic clear_commit();
      i_commit_valid = 1'b0;
      i_commit_cause = EXC_CAUSE_NOP;
      i_commit_pc    = 32'h0;
      i_commit_in_ds = 1'b0;
      i_commit_eret  = 1'b0;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      clear_commit();
      i_int_raw = 6'h0; i_cp0_status = 32'h0; i_cp0_epc = 32'h0; i_redirect_ready = 1'b0;
      tick(); tick();
      total_cnt++; if (o_stall_commit !== 1'b0) $display("FAIL reset_stall: got %b want 0", o_stall_commit); else pass_cnt++;
      total_cnt++; if (o_cp0_except_cause !== EXC_CAUSE_NOP) $display("FAIL reset_cause: got %h want %h", o_cp0_except_cause, EXC_CAUSE_NOP); else pass_cnt++;
      total_cnt++; if ({o_flush, o_redirect_valid, o_cp0_eret, o_cp0_in_ds} !== 4'b0) $display("FAIL reset_bits: got %b want 0000", {o_flush, o_redirect_valid, o_cp0_eret, o_cp0_in_ds}); else pass_cnt++;
      total_cnt++; if (o_redirect_pc !== 32'h0) $display("FAIL reset_rpc: got %h want 0", o_redirect_pc); else pass_cnt++;
      resetn = 1'b1;
      tick();
      $display("test_reset: done");
   endtask

   task automatic test_adel();
      commit(EXC_CAUSE_ADEL, 32'h0000_1000, 1'b0, 1'b0);
      tick(); clear_commit();
      total_cnt++; if (o_cp0_except_cause !== 5'h04) $display("FAIL adel_cause: got %h want 04", o_cp0_except_cause); else pass_cnt++;
      total_cnt++; if (o_cp0_current_pc !== 32'h1000) $display("FAIL adel_pc: got %h want 00001000", o_cp0_current_pc); else pass_cnt++;
      total_cnt++; if (o_stall_commit !== 1'b1 || o_flush !== 1'b0) $display("FAIL adel_entry_ctl: got stall=%b flush=%b want 1 0", o_stall_commit, o_flush); else pass_cnt++;
      tick();
      total_cnt++; if (o_flush !== 1'b1 || o_cp0_except_cause !== EXC_CAUSE_NOP) $display("FAIL adel_flush1: got flush=%b cause=%h want 1 %h", o_flush, o_cp0_except_cause, EXC_CAUSE_NOP); else pass_cnt++;
      tick();
      total_cnt++; if (o_flush !== 1'b1 || o_redirect_valid !== 1'b0) $display("FAIL adel_flush2: got flush=%b rv=%b want 1 0", o_flush, o_redirect_valid); else pass_cnt++;
      tick();
      total_cnt++; if (o_redirect_valid !== 1'b1 || o_flush !== 1'b0) $display("FAIL adel_rvalid: got rv=%b flush=%b want 1 0", o_redirect_valid, o_flush); else pass_cnt++;
      total_cnt++; if (o_redirect_pc !== VEC) $display("FAIL adel_rpc: got %h want %h", o_redirect_pc, VEC); else pass_cnt++;
      i_redirect_ready = 1'b1;
      tick(); i_redirect_ready = 1'b0;
      total_cnt++; if (o_redirect_valid !== 1'b0 || o_stall_commit !== 1'b0) $display("FAIL adel_idle: got rv=%b stall=%b want 0 0", o_redirect_valid, o_stall_commit); else pass_cnt++;
      $display("test_adel: done");
   endtask

   task automatic test_eret();
      i_cp0_epc = 32'h0000_3004;
      commit(EXC_CAUSE_NOP, 32'h0000_2400, 1'b0, 1'b1);
      tick(); clear_commit();
      total_cnt++; if (o_cp0_eret !== 1'b1 || o_cp0_except_cause !== EXC_CAUSE_NOP) $display("FAIL eret_pulse: got eret=%b cause=%h want 1 %h", o_cp0_eret, o_cp0_except_cause, EXC_CAUSE_NOP); else pass_cnt++;
      tick();
      total_cnt++; if (o_cp0_eret !== 1'b0 || o_flush !== 1'b1) $display("FAIL eret_end: got eret=%b flush=%b want 0 1", o_cp0_eret, o_flush); else pass_cnt++;
      i_cp0_epc = 32'h0000_9999; // changes after the ERET cycle must not matter
      tick(); tick();
      total_cnt++; if (o_redirect_valid !== 1'b1 || o_redirect_pc !== 32'h3004) $display("FAIL eret_rpc: got rv=%b pc=%h want 1 00003004", o_redirect_valid, o_redirect_pc); else pass_cnt++;
      i_redirect_ready = 1'b1;
      tick(); i_redirect_ready = 1'b0;
      $display("test_eret: done");
   endtask

   task automatic test_interrupt();
      i_cp0_status = 32'h0000_0401;
      i_int_raw = 6'b000001;
      tick();
      total_cnt++; if (o_cp0_int !== 6'b000000) $display("FAIL int_sync1: got %b want 000000", o_cp0_int); else pass_cnt++;
      tick();
      total_cnt++; if (o_cp0_int !== 6'b000001) $display("FAIL int_sync2: got %b want 000001", o_cp0_int); else pass_cnt++;
      tick(); // no valid commit: interrupt must wait
      total_cnt++; if (o_stall_commit !== 1'b0) $display("FAIL int_wait: got stall=%b want 0", o_stall_commit); else pass_cnt++;
      commit(EXC_CAUSE_NOP, 32'h0000_2000, 1'b1, 1'b0);
      tick(); clear_commit();
      total_cnt++; if (o_cp0_except_cause !== EXC_CAUSE_INT || o_cp0_in_ds !== 1'b1 || o_cp0_current_pc !== 32'h2000) $display("FAIL int_entry: got cause=%h ds=%b pc=%h want 00 1 00002000", o_cp0_except_cause, o_cp0_in_ds, o_cp0_current_pc); else pass_cnt++;
      tick(); tick(); tick();
      total_cnt++; if (o_redirect_valid !== 1'b1 || o_redirect_pc !== VEC) $display("FAIL int_rpc: got rv=%b pc=%h want 1 %h", o_redirect_valid, o_redirect_pc, VEC); else pass_cnt++;
      i_redirect_ready = 1'b1;
      tick(); i_redirect_ready = 1'b0;
      $display("test_interrupt: done");
   endtask

   task automatic test_priority_hold();
      // interrupt still pending and enabled from previous test
      commit(EXC_CAUSE_SYS, 32'h0000_4000, 1'b0, 1'b1);
      tick(); clear_commit();
      total_cnt++; if (o_cp0_except_cause !== EXC_CAUSE_INT || o_cp0_eret !== 1'b0) $display("FAIL prio_entry: got cause=%h eret=%b want 00 0", o_cp0_except_cause, o_cp0_eret); else pass_cnt++;
      i_redirect_ready = 1'b1; // ready before valid: no effect
      tick();
      total_cnt++; if (o_cp0_eret !== 1'b0 || o_flush !== 1'b1) $display("FAIL prio_flush: got eret=%b flush=%b want 0 1", o_cp0_eret, o_flush); else pass_cnt++;
      tick(); tick();
      i_redirect_ready = 1'b0;
      total_cnt++; if (o_redirect_valid !== 1'b1) $display("FAIL early_ready: got rv=%b want 1", o_redirect_valid); else pass_cnt++;
      for (int k = 0; k < 5; k++) begin
         tick();
         total_cnt++; if (o_redirect_valid !== 1'b1 || o_redirect_pc !== VEC) $display("FAIL hold_%0d: got rv=%b pc=%h want 1 %h", k, o_redirect_valid, o_redirect_pc, VEC); else pass_cnt++;
      end
      i_redirect_ready = 1'b1;
      tick(); i_redirect_ready = 1'b0;
      total_cnt++; if (o_redirect_valid !== 1'b0 || o_stall_commit !== 1'b0) $display("FAIL hold_release: got rv=%b stall=%b want 0 0", o_redirect_valid, o_stall_commit); else pass_cnt++;
      $display("test_priority_hold: done");
   endtask

   task automatic test_exl();
      i_cp0_status = 32'h0000_0403; // EXL masks the pending interrupt
      commit(EXC_CAUSE_SYS, 32'h0000_5000, 1'b0, 1'b0);
      tick(); clear_commit();
      total_cnt++; if (o_cp0_except_cause !== EXC_CAUSE_SYS || o_cp0_current_pc !== 32'h5000) $display("FAIL exl_entry: got cause=%h pc=%h want 08 00005000", o_cp0_except_cause, o_cp0_current_pc); else pass_cnt++;
      tick(); tick(); tick();
      i_redirect_ready = 1'b1;
      tick(); i_redirect_ready = 1'b0;
      i_int_raw = 6'h0; i_cp0_status = 32'h0;
      tick(); tick();
      $display("test_exl: done");
   endtask

   task automatic test_reset_midflush();
      commit(EXC_CAUSE_ADEL, 32'h0000_6000, 1'b1, 1'b0);
      tick(); clear_commit();
      tick();
      total_cnt++; if (o_flush !== 1'b1) $display("FAIL rst_pre: got flush=%b want 1", o_flush); else pass_cnt++;
      #2 resetn = 1'b0;
      #1;
      total_cnt++; if (o_flush !== 1'b0 || o_stall_commit !== 1'b0 || o_redirect_valid !== 1'b0) $display("FAIL rst_async: got flush=%b stall=%b rv=%b want 0 0 0", o_flush, o_stall_commit, o_redirect_valid); else pass_cnt++;
      total_cnt++; if (o_cp0_current_pc !== 32'h0 || o_cp0_in_ds !== 1'b0 || o_cp0_except_cause !== EXC_CAUSE_NOP) $display("FAIL rst_vals: got pc=%h ds=%b cause=%h want 0 0 %h", o_cp0_current_pc, o_cp0_in_ds, o_cp0_except_cause, EXC_CAUSE_NOP); else pass_cnt++;
      #2 resetn = 1'b1;
      commit(EXC_CAUSE_OV, 32'h0000_7000, 1'b0, 1'b0);
      tick(); clear_commit();
      total_cnt++; if (o_cp0_except_cause !== EXC_CAUSE_OV || o_cp0_current_pc !== 32'h7000) $display("FAIL rst_after_entry: got cause=%h pc=%h want 0c 00007000", o_cp0_except_cause, o_cp0_current_pc); else pass_cnt++;
      tick(); tick(); tick();
      total_cnt++; if (o_redirect_valid !== 1'b1 || o_redirect_pc !== VEC) $display("FAIL rst_after_rpc: got rv=%b pc=%h want 1 %h", o_redirect_valid, o_redirect_pc, VEC); else pass_cnt++;
      i_redirect_ready = 1'b1;
      tick(); i_redirect_ready = 1'b0;
      $display("test_reset_midflush: done");
   endtask

   initial begin
      test_reset();
      test_adel();
      test_eret();
      test_interrupt();
      test_priority_hold();
      test_exl();
      test_reset_midflush();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
